// File: rtl/bcd_cascade_counter_pkg.sv
// Shared definitions for the cascaded BCD/radix counter: digit width and per-digit arithmetic.
package bcd_cascade_counter_pkg;

    localparam int DIGIT_W = 4;

    function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d, input int mod);
        return (int'(d) >= mod) ? DIGIT_W'(mod - 1) : d;
    endfunction

    function automatic logic [DIGIT_W-1:0] step_digit(input logic [DIGIT_W-1:0] d,
                                                      input logic up, input int mod);
        if (up)
            return (d == DIGIT_W'(mod - 1)) ? '0 : d + DIGIT_W'(1);
        else
            return (d == '0) ? DIGIT_W'(mod - 1) : d - DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One radix-MOD digit with load clamping and up/down step; digit_nxt lets the parent
// register flags that agree with the digit value in the same cycle.
module bcd_digit
    import bcd_cascade_counter_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic               up,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    output logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] digit_nxt,
    output logic               at_max,
    output logic               at_zero
);

    logic [DIGIT_W-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load)
            digit_d = sat_digit(load_digit, MOD);
        else if (step)
            digit_d = step_digit(digit_q, up, MOD);
    end

    always_ff @(posedge clk) begin
        if (rst)
            digit_q <= '0;
        else
            digit_q <= digit_d;
    end

    assign digit     = digit_q;
    assign digit_nxt = digit_d;
    assign at_max    = (digit_q == DIGIT_W'(MOD - 1));
    assign at_zero   = (digit_q == '0);

endmodule

// File: rtl/bcd_cascade_counter.sv
// DIGITS cascaded radix-MOD digits with up/down count, parallel load and registered
// carry-out, borrow-out and whole-counter wrap flags.
module bcd_cascade_counter
    import bcd_cascade_counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int MOD    = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    output logic [DIGIT_W*DIGITS-1:0] count,
    output logic                      co,
    output logic                      bo,
    output logic                      wrap
);

    logic [DIGITS-1:0] at_max, at_zero, step;
    logic [DIGITS-1:0] nxt_max, nxt_zero;
    logic              run;
    logic              co_q, bo_q, wrap_q;
    logic              co_d, bo_d, wrap_d;

    // Carry/borrow enable: a digit steps only when every lower digit is at its turning point.
    always_comb begin
        run  = en;
        step = '0;
        for (int i = 0; i < DIGITS; i++) begin
            step[i] = run;
            run     = run & (up ? at_max[i] : at_zero[i]);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [DIGIT_W-1:0] nxt;

        bcd_digit #(.MOD(MOD)) u_digit (
            .clk        (clk),
            .rst        (rst),
            .step       (step[g]),
            .up         (up),
            .load       (load),
            .load_digit (load_val[g*DIGIT_W +: DIGIT_W]),
            .digit      (count[g*DIGIT_W +: DIGIT_W]),
            .digit_nxt  (nxt),
            .at_max     (at_max[g]),
            .at_zero    (at_zero[g])
        );

        assign nxt_max[g]  = (nxt == DIGIT_W'(MOD - 1));
        assign nxt_zero[g] = (nxt == '0);
    end

    always_comb begin
        co_d   = &nxt_max;
        bo_d   = &nxt_zero;
        wrap_d = run & ~load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            co_q   <= 1'b0;
            bo_q   <= 1'b1;
            wrap_q <= 1'b0;
        end else begin
            co_q   <= co_d;
            bo_q   <= bo_d;
            wrap_q <= wrap_d;
        end
    end

    assign co   = co_q;
    assign bo   = bo_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed + random check of two counter builds (2 x radix 10, 2 x radix 16) against an
// integer-valued model of the counter.
module tb_bcd_cascade_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [7:0] load_val = '0;
    logic [7:0] count10, count16;
    logic       co10, bo10, wrap10, co16, bo16, wrap16;

    int n_assert = 0;
    int n_fail   = 0;

    int v10 = 0, v16 = 0;
    bit w10 = 0, w16 = 0;

    always #5 clk = ~clk;

    bcd_cascade_counter #(.DIGITS(2), .MOD(10)) u_dec (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count10), .co(co10), .bo(bo10), .wrap(wrap10)
    );

    bcd_cascade_counter #(.DIGITS(2), .MOD(16)) u_hex (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count16), .co(co16), .bo(bo16), .wrap(wrap16)
    );

    function automatic logic [7:0] to_digits(input int v, input int m);
        return 8'(((v / m) % m) * 16 + (v % m));
    endfunction

    function automatic int from_load(input logic [7:0] lv, input int m);
        int hi, lo;
        hi = (int'(lv[7:4]) >= m) ? m - 1 : int'(lv[7:4]);
        lo = (int'(lv[3:0]) >= m) ? m - 1 : int'(lv[3:0]);
        return hi * m + lo;
    endfunction

    task automatic model_step(inout int v, inout bit w, input int m);
        int span;
        span = m * m;
        if (rst) begin
            v = 0; w = 0;
        end else if (load) begin
            v = from_load(load_val, m); w = 0;
        end else if (en) begin
            if (up) begin
                w = (v == span - 1); v = (v + 1) % span;
            end else begin
                w = (v == 0); v = (v + span - 1) % span;
            end
        end else begin
            w = 0;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("dec_count", count10, to_digits(v10, 10));
        check("dec_co",    8'(co10),   8'(v10 == 99));
        check("dec_bo",    8'(bo10),   8'(v10 == 0));
        check("dec_wrap",  8'(wrap10), 8'(w10));
        check("hex_count", count16, to_digits(v16, 16));
        check("hex_co",    8'(co16),   8'(v16 == 255));
        check("hex_bo",    8'(bo16),   8'(v16 == 0));
        check("hex_wrap",  8'(wrap16), 8'(w16));
    endtask

    task automatic tick(input logic r, input logic l, input logic [7:0] lv,
                        input logic e, input logic u);
        rst = r; load = l; load_val = lv; en = e; up = u;
        @(posedge clk);
        model_step(v10, w10, 10);
        model_step(v16, w16, 16);
        #1;
        check_all();
    endtask

    initial begin
        // Reset, then 100 up-steps: 00..99 and back to 00 with a single wrap.
        tick(1, 0, 8'h00, 0, 1);
        check("rst_bo_const", 8'(bo10), 8'd1);
        for (int i = 0; i < 100; i++) tick(0, 0, 8'h00, 1, 1);
        check("up100_count", count10, 8'h00);
        check("up100_wrap",  8'(wrap10), 8'd1);

        // Down across a borrow from 10 through 00 to 99.
        tick(0, 1, 8'h10, 0, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, 8'h00, 1, 0);
        check("down_zero_bo", 8'(bo10), 8'd1);
        tick(0, 0, 8'h00, 1, 0);
        check("down_wrap_count", count10, 8'h99);
        check("down_wrap_flag",  8'(wrap10), 8'd1);

        // Load saturation beats en.
        tick(0, 1, 8'hF3, 1, 1);
        check("load_sat", count10, 8'h93);
        check("load_hex", count16, 8'hF3);

        // Hold, then direction toggling around 49/50.
        for (int i = 0; i < 5; i++) tick(0, 0, 8'h00, 0, 1);
        check("hold_value", count10, 8'h93);
        tick(0, 1, 8'h49, 0, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, 8'h00, 1, (i % 2) == 0);
        check("toggle_end", count10, 8'h49);

        // Reset on the edge that would otherwise wrap.
        tick(0, 1, 8'h99, 0, 1);
        tick(1, 0, 8'h00, 1, 1);
        check("rst_wrap_count", count10, 8'h00);
        check("rst_wrap_flag",  8'(wrap10), 8'd0);

        // Radix 16 rollover from FE.
        tick(0, 1, 8'hFE, 0, 1);
        tick(0, 0, 8'h00, 1, 1);
        check("hex_ff_co", 8'(co16), 8'd1);
        tick(0, 0, 8'h00, 1, 1);
        check("hex_wrap_count", count16, 8'h00);
        check("hex_wrap_flag",  8'(wrap16), 8'd1);

        // Random mix of all controls.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                 8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
